psram_bram_responder: RTL

//  Responder for the PSRAM request/response interface (stb/we/addr/din -> busy/done/dout).

---
 rtl/psram_bram_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/psram_bram_responder.sv
// ---------------------------------------------------------------------------
// psram_bram_responder
//
// Stand-in for the external PSRAM controller. It answers the same
// request/response handshake (stb/we/addr/din -> busy/done/dout) from an
// on-chip block RAM, with a programmable power-up delay and fixed per-access
// delays. Display and test logic can then be brought up and debugged
// without the external PSRAM fitted.
//
// Ports
//   i_clk    in   1   clock (100 MHz domain)
//   i_rst    in   1   asynchronous, active-high reset
//   i_stb    in   1   request strobe, level-sensitive, taken only in IDLE
//   i_we     in   1   1 = write, 0 = read, sampled with i_stb
//   i_addr   in   24  word address; only the low ADDR_BITS bits are used
//   i_din    in   16  write data, sampled with i_stb
//   o_busy   out  1   startup or access in progress
//   o_done   out  1   one-cycle completion pulse
//   o_dout   out  16  data from the last completed read
//   o_state  out  6   FSM code, for on-screen state display
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STARTUP  | power-up delay; busy held, requests ignored      (code 0)
// IDLE     | ready; a request is accepted on any edge with stb (code 1)
// WRITE    | write latency countdown; RAM written at the end   (code 2)
// READ     | read latency countdown; o_dout loaded at the end  (code 3)
// ---------------------------------------------------------------------------
module psram_bram_responder #(
    parameter int ADDR_BITS      = 10,
    parameter int WR_LATENCY     = 4,
    parameter int RD_LATENCY     = 6,
    parameter int STARTUP_CYCLES = 15000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [23:0] i_addr,
    input  logic [15:0] i_din,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_dout,
    output logic [5:0]  o_state
);

    localparam int DEPTH   = 2 ** ADDR_BITS;
    localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
    localparam int MAX_CNT = (STARTUP_CYCLES > MAX_LAT) ? STARTUP_CYCLES : MAX_LAT;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT + 1) : 1;

    localparam logic [CW-1:0] SU_LAST = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_LATENCY - 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_LATENCY - 1);

    typedef enum logic [5:0] {
        ST_STARTUP = 6'd0,
        ST_IDLE    = 6'd1,
        ST_WRITE   = 6'd2,
        ST_READ    = 6'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [15:0]            din_q;
    logic [15:0]            rd_data;
    logic                   wr_commit;
    logic [15:0]            ram [DEPTH];

    // Upper address bits alias onto the RAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[23:ADDR_BITS];

    assign o_state   = state;
    assign wr_commit = (state == ST_WRITE) && (cnt == '0);

    // Startup counts up to its terminal value from the reset value of zero;
    // accesses reuse the same counter as a down-counter to zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= ST_STARTUP;
            cnt    <= '0;
            o_busy <= 1'b1;
            o_done <= 1'b0;
            o_dout <= '0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_STARTUP: begin
                    if (cnt == SU_LAST) begin
                        cnt    <= '0;
                        o_busy <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_stb) begin
                        addr_q <= i_addr[ADDR_BITS-1:0];
                        din_q  <= i_din;
                        o_busy <= 1'b1;
                        if (i_we) begin
                            cnt   <= WR_LOAD;
                            state <= ST_WRITE;
                        end else begin
                            cnt   <= RD_LOAD;
                            state <= ST_READ;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (cnt == '0) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                        if (state == ST_READ) begin
                            o_dout <= rd_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_STARTUP;
                    cnt    <= '0;
                    o_busy <= 1'b1;
                end
            endcase
        end
    end

    // Single-port read-first RAM, no reset so it maps onto block RAM and
    // keeps its contents across i_rst. addr_q is stable for the whole access
    // and latency is at least two, so rd_data has settled on the addressed
    // word (including a write that completed on the accept edge) by the
    // completion edge.
    always_ff @(posedge i_clk) begin
        if (wr_commit) begin
            ram[addr_q] <= din_q;
        end
        rd_data <= ram[addr_q];
    end

endmodule
